// File: rtl/pkt_router_pkg.sv
// Shared definitions for the packet router ingress path: packet field layout and arbiter state encoding.
package pkt_router_pkg;

    localparam int PKT_W    = 20;
    localparam int HDR_MSB  = 19;
    localparam int HDR_LSB  = 16;
    localparam int PAY_MSB  = 15;
    localparam int PAY_LSB  = 0;
    localparam int PORT_MSB = 1;
    localparam int PORT_LSB = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping around.
// Also usable for output-port scheduling.
module rr_pick
    import pkt_router_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    always_comb begin
        logic [IW:0] cand;
        idx_o = last_i;
        any_o = 1'b0;
        cand  = '0;
        // One extra bit keeps last_i + k from wrapping before the modulo on non-power-of-two sizes.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!any_o && req_i[cand[IW-1:0]]) begin
                idx_o = cand[IW-1:0];
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_ingress_arbiter.sv
// Round-robin, credit-flow-controlled arbiter feeding the packet router's single ingress.
// Bursts per grant are bounded; one credit comes back per router output pulse.
module pkt_ingress_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PKT_W     = pkt_router_pkg::PKT_W,
    parameter int CREDITS   = 32,
    parameter int BURST_MAX = 4,
    localparam int GW       = $clog2(NUM_REQ),
    localparam int CW       = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rtr_packet_valid,
    output logic [PKT_W-1:0]         rtr_data_packet,
    input  logic                     rtr_done,
    output logic [GW-1:0]            grant_id,
    output logic [CW-1:0]            credits,
    output logic [15:0]              pkt_count,
    output logic                     err_credit_ovf
);
    import pkt_router_pkg::*;

    localparam int BW = $clog2(BURST_MAX + 1);

    arb_state_t       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic [15:0]      pkt_q, pkt_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic [PKT_W-1:0] data_q, data_d, sel_data;
    logic [CW:0]      credits_eff;
    logic             serve_ok, xfer, pick_any;
    logic [GW-1:0]    pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (GW)
    ) u_pick (
        .req_i  (req_valid),
        .last_i (grant_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // A credit returning this cycle may be spent in the same cycle.
    assign credits_eff = {1'b0, credits_q} + {{CW{1'b0}}, rtr_done};
    assign serve_ok    = (state_q == SERVE) && enable && (credits_eff != '0);

    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                req_ready[i] = serve_ok;
                sel_data     = req_data[i*PKT_W +: PKT_W];
            end
        end
    end

    assign xfer = |(req_ready & req_valid);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        burst_d   = burst_q;
        credits_d = credits_q;
        pkt_d     = pkt_q;
        err_d     = err_q;
        vld_d     = xfer;
        data_d    = xfer ? sel_data : data_q;

        if (xfer) begin
            pkt_d = pkt_q + 16'd1;
        end

        if (xfer && !rtr_done) begin
            credits_d = credits_q - 1'b1;
        end else if (!xfer && rtr_done) begin
            if (credits_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable && (credits_q != '0) && pick_any) begin
                    grant_d = pick_idx;
                    burst_d = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (xfer) begin
                    burst_d = burst_q + 1'b1;
                end
                if (!xfer || (burst_d == BW'(BURST_MAX)) || (credits_d == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= GW'(NUM_REQ - 1);
            burst_q   <= '0;
            credits_q <= CW'(CREDITS);
            pkt_q     <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            burst_q   <= burst_d;
            credits_q <= credits_d;
            pkt_q     <= pkt_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
        end
    end

    assign rtr_packet_valid = vld_q;
    assign rtr_data_packet  = data_q;
    assign grant_id         = grant_q;
    assign credits          = credits_q;
    assign pkt_count        = pkt_q;
    assign err_credit_ovf   = err_q;

endmodule

// File: tb/tb_pkt_ingress_arbiter.sv
// Self-checking bench for pkt_ingress_arbiter: queue-fed sources, a transaction-level reference model and directed scenarios.
module tb_pkt_ingress_arbiter;

    localparam int N  = 4;
    localparam int PW = 20;
    localparam int CR = 32;
    localparam int BM = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            rtr_done = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*PW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rtr_packet_valid;
    logic [PW-1:0]   rtr_data_packet;
    logic [1:0]      grant_id;
    logic [5:0]      credits;
    logic [15:0]     pkt_count;
    logic            err_credit_ovf;

    pkt_ingress_arbiter #(
        .NUM_REQ   (N),
        .PKT_W     (PW),
        .CREDITS   (CR),
        .BURST_MAX (BM)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .rtr_packet_valid (rtr_packet_valid),
        .rtr_data_packet  (rtr_data_packet),
        .rtr_done         (rtr_done),
        .grant_id         (grant_id),
        .credits          (credits),
        .pkt_count        (pkt_count),
        .err_credit_ovf   (err_credit_ovf)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit            m_serving;
    int            m_grant, m_burst, m_cred;
    logic          m_vld, m_err;
    logic [PW-1:0] m_data;
    logic [15:0]   m_pkt;

    // Sources and bookkeeping
    logic [PW-1:0] mem [N][64];
    int            head [N];
    int            tail [N];
    bit            gate [N];
    int            done_mode;
    bit            rand_mode;
    logic [N-1:0]  hs;
    int            cyc = 0;
    int            n_log = 0;
    int            log_src [64];
    int            log_cyc [64];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_serving && enable && (m_cred + (rtr_done ? 1 : 0)) > 0) r = N'(1) << m_grant;
        return r;
    endfunction

    task automatic model_reset();
        m_serving = 1'b0;
        m_grant   = N - 1;
        m_burst   = 0;
        m_cred    = CR;
        m_vld     = 1'b0;
        m_data    = '0;
        m_pkt     = '0;
        m_err     = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0]    rdy, sh;
        logic [N*PW-1:0] dsh;
        bit              xfer;
        int              cred_old, pick, j;
        rdy      = model_ready();
        xfer     = |(rdy & req_valid);
        cred_old = m_cred;
        m_vld    = xfer;
        if (xfer) begin
            dsh    = req_data >> (m_grant * PW);
            m_data = dsh[PW-1:0];
            m_pkt  = m_pkt + 16'd1;
        end
        if (xfer && !rtr_done) m_cred--;
        else if (!xfer && rtr_done) begin
            if (m_cred == CR) m_err = 1'b1;
            else m_cred++;
        end
        if (!m_serving) begin
            if (enable && cred_old > 0 && |req_valid) begin
                pick = -1;
                for (int k = 1; k <= N; k++) begin
                    j  = (m_grant + k) % N;
                    sh = req_valid >> j;
                    if (pick < 0 && sh[0]) pick = j;
                end
                m_grant   = pick;
                m_burst   = 0;
                m_serving = 1'b1;
            end
        end else begin
            if (xfer) m_burst++;
            if (!xfer || m_burst == BM || m_cred == 0) m_serving = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = gate[i] && (head[i] < tail[i]);
            req_data[i*PW +: PW]  = (head[i] < tail[i]) ? mem[i][head[i]] : '0;
        end
    endtask

    task automatic load_src(int i, int n);
        head[i] = 0;
        tail[i] = n;
        for (int k = 0; k < n; k++) mem[i][k] = PW'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        hs = req_valid & req_ready;
        cyc++;
        if (rst) model_reset();
        else model_step();
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (n_log < 64) begin
                    log_src[n_log] = i;
                    log_cyc[n_log] = cyc;
                end
                n_log++;
            end
        end
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) head[i]++;
        if (rand_mode) begin
            rst    = ($urandom_range(299) == 0);
            enable = ($urandom_range(9) != 0);
            for (int i = 0; i < N; i++) begin
                gate[i] = ($urandom_range(3) != 0);
                if (head[i] >= tail[i]) load_src(i, int'($urandom_range(8, 1)));
            end
        end
        case (done_mode)
            0: rtr_done = 1'b0;
            1: rtr_done = (m_cred < CR) && ($urandom_range(2) == 0);
            2: rtr_done = (m_cred < CR);
            default: ;
        endcase
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; done_mode = 3; rtr_done = 1'b0; rand_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; gate[i] = 1'b1;
        end
        drive_inputs();
        step();
        chk_en = 1'b1;
        step();
        rst   = 1'b0;
        n_log = 0;
    endtask

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("req_ready", 32'(req_ready), 32'(model_ready()));
                chk("rtr_packet_valid", 32'(rtr_packet_valid), 32'(m_vld));
                chk("rtr_data_packet", 32'(rtr_data_packet), 32'(m_data));
                chk("grant_id", 32'(grant_id), 32'(m_grant));
                chk("credits", 32'(credits), 32'(m_cred));
                chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
                chk("err_credit_ovf", 32'(err_credit_ovf), 32'(m_err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();

        // Reset then idle
        do_reset();
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_valid", 32'(rtr_packet_valid), 32'h0);
        chk("t1_data", 32'(rtr_data_packet), 32'h0);
        chk("t1_grant", 32'(grant_id), 32'd3);
        chk("t1_credits", 32'(credits), 32'd32);
        chk("t1_pkt", 32'(pkt_count), 32'd0);
        chk("t1_err", 32'(err_credit_ovf), 32'd0);
        repeat (10) step();
        @(negedge clk);
        chk("t1_idle_pkt", 32'(pkt_count), 32'd0);
        chk("t1_idle_xfers", 32'(n_log), 32'd0);

        // Single source, 6 packets
        do_reset();
        head[2] = 0; tail[2] = 6;
        for (int k = 0; k < 6; k++) mem[2][k] = PW'(k + 1);
        enable = 1'b1; done_mode = 0; drive_inputs();
        for (int t = 0; t < 40 && n_log < 6; t++) step();
        chk("t2_xfers", 32'(n_log), 32'd6);
        begin
            int from2;
            from2 = 0;
            for (int k = 0; k < 6; k++) if (log_src[k] == 2) from2++;
            chk("t2_src", 32'(from2), 32'd6);
        end
        chk("t2_burst1_span", 32'(log_cyc[3] - log_cyc[0]), 32'd3);
        chk("t2_gap", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
        chk("t2_burst2_span", 32'(log_cyc[5] - log_cyc[4]), 32'd1);
        @(negedge clk);
        chk("t2_credits", 32'(credits), 32'd26);
        chk("t2_pkt", 32'(pkt_count), 32'd6);
        chk("t2_grant", 32'(grant_id), 32'd2);
        chk("t2_last_data", 32'(rtr_data_packet), 32'h6);

        // Fairness with all four requesters streaming
        do_reset();
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 8;
            for (int k = 0; k < 8; k++) mem[i][k] = PW'((i << 16) | k);
        end
        enable = 1'b1; done_mode = 2; drive_inputs();
        for (int t = 0; t < 120 && n_log < 20; t++) step();
        chk("t3_xfers", 32'(n_log >= 20), 32'd1);
        for (int k = 0; k < 20; k++) chk("t3_order", 32'(log_src[k]), 32'((k / 4) % 4));

        // Credit exhaustion
        do_reset();
        for (int i = 0; i < N; i++) load_src(i, 12);
        enable = 1'b1; done_mode = 0; drive_inputs();
        repeat (100) step();
        @(negedge clk);
        chk("t4_pkt", 32'(pkt_count), 32'd32);
        chk("t4_xfers", 32'(n_log), 32'd32);
        chk("t4_credits", 32'(credits), 32'd0);
        chk("t4_ready", 32'(req_ready), 32'h0);
        done_mode = 3; rtr_done = 1'b1;
        step();
        rtr_done = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("t4_one_more", 32'(pkt_count), 32'd33);
        chk("t4_credits_after", 32'(credits), 32'd0);

        // Transfer and credit return together at credits=1
        do_reset();
        load_src(0, 40);
        enable = 1'b1; done_mode = 3; drive_inputs();
        for (int t = 0; t < 80 && credits != 6'd1; t++) step();
        chk("t5_reach", 32'(credits), 32'd1);
        gate[0] = 1'b0; drive_inputs();
        step();
        gate[0] = 1'b1; drive_inputs();
        step();
        rtr_done = 1'b1;
        step();
        rtr_done = 1'b0;
        @(negedge clk);
        chk("t5_credits_hold", 32'(credits), 32'd1);
        chk("t5_pkt", 32'(pkt_count), 32'd32);
        chk("t5_burst_cont", 32'(req_ready), 32'h1);
        step();
        @(negedge clk);
        chk("t5_credits_zero", 32'(credits), 32'd0);
        chk("t5_pkt_final", 32'(pkt_count), 32'd33);

        // Credit return with a full credit count
        do_reset();
        rtr_done = 1'b1;
        step();
        rtr_done = 1'b0;
        @(negedge clk);
        chk("t5_err", 32'(err_credit_ovf), 32'd1);
        chk("t5_err_credits", 32'(credits), 32'd32);
        step();
        @(negedge clk);
        chk("t5_err_sticky", 32'(err_credit_ovf), 32'd1);

        // Mid-burst enable drop and reset
        do_reset();
        head[1] = 0; tail[1] = 10;
        for (int k = 0; k < 10; k++) mem[1][k] = PW'(32'h100 + k);
        enable = 1'b1; done_mode = 0; drive_inputs();
        for (int t = 0; t < 20 && n_log < 2; t++) step();
        chk("t6_two", 32'(n_log), 32'd2);
        enable = 1'b0;
        @(negedge clk);
        chk("t6_ready_drop", 32'(req_ready), 32'h0);
        chk("t6_still_presented", 32'(rtr_packet_valid), 32'd1);
        chk("t6_presented_data", 32'(rtr_data_packet), 32'h101);
        step();
        @(negedge clk);
        chk("t6_no_xfer", 32'(rtr_packet_valid), 32'd0);
        chk("t6_pkt", 32'(pkt_count), 32'd2);
        enable = 1'b1;
        for (int t = 0; t < 20 && !rtr_packet_valid; t++) step();
        chk("t6_valid_before_rst", 32'(rtr_packet_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 32'(rtr_packet_valid), 32'd0);
        chk("t6_rst_credits", 32'(credits), 32'd32);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < N; i++) load_src(i, int'($urandom_range(8, 1)));
        enable = 1'b1; done_mode = 1; rand_mode = 1'b1; drive_inputs();
        repeat (3000) step();
        rand_mode = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
